// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared ALU opcode, FSM state and shift-field definitions
package alu_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SHIFT  = 2'b01,
        OP_ROTATE = 2'b10,
        OP_SUB    = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_RESP  = 2'b10
    } issue_state_e;

    // SHIFT/ROTATE encode direction and amount inside operand 2
    localparam int SHIFT_DIR_BIT = 0;
    localparam int SHIFT_AMT_LSB = 1;
    localparam int SHIFT_AMT_W   = 4;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// rtl/alu_issue_ctrl_regfile.sv - 2R1W register file with R0 hardwired to zero
module alu_issue_ctrl_regfile #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0]  rdata1,
    input  logic [RADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]  rdata2,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata
);

    localparam int NREG = 2 ** RADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            regs[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (we && (waddr == RADDR_W'(i))) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one register-file command to an external ALU and returns its result
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3,
    parameter int IMM_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [RADDR_W-1:0] cmd_rd,
    input  logic [RADDR_W-1:0] cmd_rs,
    input  logic [RADDR_W-1:0] cmd_rt,
    input  logic               cmd_use_imm,
    input  logic [IMM_W-1:0]   cmd_imm,
    output logic [DATA_W-1:0]  alu_data1,
    output logic [DATA_W-1:0]  alu_data2,
    output logic [1:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_zero,
    output logic [RADDR_W-1:0] rsp_rd
);

    issue_state_e       state_q, state_d;
    logic               init_q;
    logic               accept;
    logic               capture;
    logic [RADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]  rs_data, rt_data;
    logic [DATA_W-1:0]  op2_sel;

    alu_issue_ctrl_regfile #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (cmd_rs),
        .rdata1 (rs_data),
        .raddr2 (cmd_rt),
        .rdata2 (rt_data),
        .we     (capture && (rd_q != '0)),
        .waddr  (rd_q),
        .wdata  (alu_result)
    );

    assign op2_sel = cmd_use_imm ? {{(DATA_W-IMM_W){1'b0}}, cmd_imm} : rt_data;

    // init_q keeps cmd_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = init_q;
                if (cmd_valid && init_q) begin
                    accept  = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_valid = (state_q == ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_op     <= OP_ADD;
            rd_q       <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_rd     <= '0;
        end else begin
            if (accept) begin
                alu_data1 <= rs_data;
                alu_data2 <= op2_sel;
                alu_op    <= cmd_op;
                rd_q      <= cmd_rd;
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_rd     <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed and randomized checks of alu_issue_ctrl against a register-file model
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rs, cmd_rt;
    logic        cmd_use_imm;
    logic [4:0]  cmd_imm;
    logic [15:0] alu_data1, alu_data2;
    logic [1:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_zero;
    logic [2:0]  rsp_rd;

    int pass_cnt  = 0;
    int total_cnt = 0;
    longint unsigned mreg [8];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs      (cmd_rs),
        .cmd_rt      (cmd_rt),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_rd      (rsp_rd)
    );

    // Combinational 16-bit ALU driven by the DUT operands
    logic [3:0] alu_amt;
    always_comb begin
        alu_amt    = alu_data2[4:1];
        alu_result = '0;
        case (alu_op)
            2'b00: alu_result = alu_data1 + alu_data2;
            2'b01: alu_result = alu_data2[0] ? (alu_data1 << alu_amt) : (alu_data1 >> alu_amt);
            2'b10: alu_result = alu_data2[0]
                       ? ((alu_data1 << alu_amt) | (alu_data1 >> (5'd16 - {1'b0, alu_amt})))
                       : ((alu_data1 >> alu_amt) | (alu_data1 << (5'd16 - {1'b0, alu_amt})));
            default: alu_result = alu_data1 - alu_data2;
        endcase
        alu_zero = (alu_result == 16'h0000);
    end

    function automatic longint unsigned ref_result(int op, longint unsigned a, longint unsigned b);
        longint unsigned amt  = (b / 2) % 16;
        longint unsigned p    = longint'(1) << amt;
        longint unsigned q    = longint'(1) << (16 - amt);
        bit              left = (b % 2) == 1;
        case (op)
            0:       return (a + b) % 65536;
            1:       return left ? (a * p) % 65536 : a / p;
            2:       return left ? ((a * p) % 65536) + a / q : a / p + (a * q) % 65536;
            default: return (a + 65536 - b) % 65536;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic issue(input int op, input int rd, input int rs, input int rt,
                         input bit use_imm, input int imm, input int stall, input int lit);
        longint unsigned d1, d2, res;
        d1  = mreg[rs];
        d2  = use_imm ? longint'(imm) : mreg[rt];
        res = ref_result(op, d1, d2);
        @(negedge clk);
        cmd_op      = 2'(op);
        cmd_rd      = 3'(rd);
        cmd_rs      = 3'(rs);
        cmd_rt      = 3'(rt);
        cmd_use_imm = use_imm;
        cmd_imm     = 5'(imm);
        cmd_valid   = 1'b1;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("alu_data1", 32'(alu_data1), 32'(d1));
        check("alu_data2", 32'(alu_data2), 32'(d2));
        check("alu_op", 32'(alu_op), 32'(op));
        check("rsp_valid_drive", 32'(rsp_valid), 32'd0);
        check("cmd_ready_drive", 32'(cmd_ready), 32'd0);
        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        check("rsp_valid_resp", 32'(rsp_valid), 32'd1);
        check("rsp_result", 32'(rsp_result), 32'(res));
        check("rsp_zero", 32'(rsp_zero), 32'(res == 0));
        check("rsp_rd", 32'(rsp_rd), 32'(rd));
        if (lit >= 0) check("rsp_result_literal", 32'(rsp_result), 32'(lit));
        if (rd != 0) mreg[rd] = res;
        for (int s = 0; s < stall; s++) begin
            cmd_valid = 1'b1;
            cmd_rs    = 3'($urandom_range(7));
            cmd_imm   = 5'($urandom_range(31));
            @(posedge clk); #1;
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_result", 32'(rsp_result), 32'(res));
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_alu_data1", 32'(alu_data1), 32'(d1));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("rsp_valid_done", 32'(rsp_valid), 32'd0);
        check("cmd_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mreg[i] = 0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_rd      = '0;
        cmd_rs      = '0;
        cmd_rt      = '0;
        cmd_use_imm = 1'b0;
        cmd_imm     = '0;
        rsp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);
        check("reset_alu_data1", 32'(alu_data1), 32'd0);
        check("reset_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

        issue(0, 1, 0, 0, 1'b1, 5, 0, 16'h0005);
        issue(1, 2, 1, 0, 1'b1, 5'b00111, 0, 16'h0028);
        issue(1, 3, 2, 0, 1'b1, 5'b00100, 0, 16'h000A);
        issue(0, 4, 0, 0, 1'b1, 1, 0, 16'h0001);
        issue(2, 4, 4, 0, 1'b1, 5'b00010, 0, 16'h8000);
        issue(2, 4, 4, 0, 1'b1, 5'b00011, 0, 16'h0001);
        issue(3, 5, 1, 1, 1'b0, 0, 0, 16'h0000);
        issue(3, 5, 0, 1, 1'b0, 0, 0, 16'hFFFB);
        issue(0, 6, 1, 3, 1'b0, 0, 5, 16'h000F);
        issue(0, 0, 0, 0, 1'b1, 7, 0, 16'h0007);
        issue(0, 1, 0, 0, 1'b0, 0, 0, 16'h0000);

        // Reset asserted while the command is in DRIVE
        @(negedge clk);
        cmd_op = 2'b00; cmd_rd = 3'd6; cmd_rs = 3'd6; cmd_use_imm = 1'b1; cmd_imm = 5'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_alu_data1", 32'(alu_data1), 32'd0);
        check("midrst_alu_data2", 32'(alu_data2), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_rsp_result", 32'(rsp_result), 32'd0);
        @(posedge clk); #1;
        check("midrst_rsp_valid_held", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 8; i++) mreg[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_cmd_ready_after", 32'(cmd_ready), 32'd1);
        issue(0, 7, 6, 0, 1'b1, 0, 0, 16'h0000);

        for (int n = 0; n < 40; n++) begin
            issue(int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(7)),
                  int'($urandom_range(7)), 1'($urandom_range(1)), int'($urandom_range(31)),
                  int'($urandom_range(2)), -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
